// File: rtl/core_id_stage_pkg.sv
// core_id_stage_pkg
//   Shared definitions for the RV32IM decode stage: widths, the bubble
//   encoding, opcode constants, operand/write-back select encodings, the
//   decoded control bundle, and the decode helpers. Those helpers are pure
//   functions, so the bubble constant can be derived from NOP_INSN at
//   elaboration time.
package core_id_stage_pkg;

    localparam int          XLEN     = 32;
    localparam int          REG_AW   = 5;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;   // ADDI x0,x0,0

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // ALU operand A select
    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;

    // Write-back source select
    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    typedef enum logic [2:0] {
        IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_e;

    // Everything the execute stage needs that comes from the instruction word.
    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   imm;
        logic [4:0]        alu_op;     // {is_muldiv, funct7[5], funct3}
        logic [1:0]        src_a_sel;
        logic              src_b_imm;
        logic              mem_rd;
        logic              mem_wr;
        logic [2:0]        mem_size;
        logic              wb_en;
        logic [1:0]        wb_sel;
        logic              branch;
        logic              jump;
        logic              jalr;
        logic              illegal;
    } id_ctrl_t;

    // Registered decode -> execute bundle.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        id_ctrl_t        ctrl;
    } id_bundle_t;

    function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] insn,
                                                input imm_fmt_e    fmt);
        logic [XLEN-1:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{insn[31]}}, insn[31:20]};
            IMM_S:   imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            IMM_B:   imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25],
                            insn[11:8], 1'b0};
            IMM_U:   imm = {insn[31:12], 12'b0};
            IMM_J:   imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20],
                            insn[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    // rs1 is read by every format except U/J; rs2 only by R/S/B.
    function automatic logic uses_rs1(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_OP_IMM) || (opc == OPC_LOAD) ||
               (opc == OPC_STORE) || (opc == OPC_BRANCH) || (opc == OPC_JALR);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

    function automatic id_ctrl_t decode_insn(input logic [31:0] insn);
        id_ctrl_t   c;
        imm_fmt_e   fmt;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        opc         = insn[6:0];
        f3          = insn[14:12];
        f7          = insn[31:25];
        fmt         = IMM_R;
        c           = '0;
        c.rs1       = insn[19:15];
        c.rs2       = insn[24:20];
        c.rd        = insn[11:7];
        c.src_b_imm = 1'b1;
        case (opc)
            OPC_OP: begin
                c.src_b_imm = 1'b0;
                c.wb_en     = 1'b1;
                case (f7)
                    7'b0000000: c.alu_op = {2'b00, f3};
                    7'b0100000: begin
                        // only SUB and SRA carry funct7[5]
                        c.alu_op  = {2'b01, f3};
                        c.illegal = !((f3 == 3'b000) || (f3 == 3'b101));
                    end
                    7'b0000001: c.alu_op = {2'b10, f3};
                    default:    c.illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                fmt      = IMM_I;
                c.wb_en  = 1'b1;
                c.alu_op = {2'b00, f3};
                if (f3 == 3'b001) begin
                    c.illegal = (f7 != 7'b0000000);
                end else if (f3 == 3'b101) begin
                    // SRLI vs SRAI; upper immediate bits are funct7 here
                    c.alu_op[3] = (f7 == 7'b0100000);
                    c.illegal   = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                end
            end
            OPC_LUI: begin
                fmt         = IMM_U;
                c.src_a_sel = SRC_A_ZERO;
                c.wb_en     = 1'b1;
            end
            OPC_AUIPC: begin
                fmt         = IMM_U;
                c.src_a_sel = SRC_A_PC;
                c.wb_en     = 1'b1;
            end
            OPC_JAL: begin
                fmt         = IMM_J;
                c.src_a_sel = SRC_A_PC;
                c.wb_en     = 1'b1;
                c.wb_sel    = WB_SEL_PC4;
                c.jump      = 1'b1;
            end
            OPC_JALR: begin
                fmt       = IMM_I;
                c.wb_en   = 1'b1;
                c.wb_sel  = WB_SEL_PC4;
                c.jump    = 1'b1;
                c.jalr    = 1'b1;
                c.illegal = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                fmt         = IMM_B;
                c.src_b_imm = 1'b0;     // comparison uses rs2; imm feeds target
                c.alu_op    = {2'b00, f3};
                c.branch    = 1'b1;
                c.illegal   = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LOAD: begin
                fmt        = IMM_I;
                c.mem_rd   = 1'b1;
                c.mem_size = f3;
                c.wb_en    = 1'b1;
                c.wb_sel   = WB_SEL_MEM;
                c.illegal  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                fmt        = IMM_S;
                c.mem_wr   = 1'b1;
                c.mem_size = f3;
                c.illegal  = (f3[2] == 1'b1) || (f3 == 3'b011);
            end
            default: c.illegal = 1'b1;
        endcase
        c.imm = gen_imm(insn, fmt);
        // An illegal instruction must not have architectural side effects.
        if (c.illegal) begin
            c.wb_en  = 1'b0;
            c.mem_rd = 1'b0;
            c.mem_wr = 1'b0;
            c.branch = 1'b0;
            c.jump   = 1'b0;
            c.jalr   = 1'b0;
        end
        if (c.rd == '0) begin
            c.wb_en = 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/core_id_stage_regfile.sv
// core_regfile
//   Integer register file: 2^REG_ADDR_WIDTH entries of DATA_WIDTH bits.
//   x0 is hardwired to zero and ignores writes. Two asynchronous read ports,
//   one synchronous write port. A read of the register being written this
//   cycle returns the incoming data (write-first bypass), so decode never
//   sees a stale operand for the instruction retiring in write-back.
// Ports:
//   clk, rst_n              clock, async active-low reset (clears all regs)
//   rs1_addr_i/rs1_data_o   read port A
//   rs2_addr_i/rs2_data_o   read port B
//   we_i, waddr_i, wdata_i  write port
module core_regfile
    import core_id_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = XLEN,
    parameter int REG_ADDR_WIDTH = REG_AW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
    output logic [DATA_WIDTH-1:0]     rs1_data_o,
    output logic [DATA_WIDTH-1:0]     rs2_data_o,
    input  logic                      we_i,
    input  logic [REG_ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i
);

    localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_d, regs_q;
    logic                                wr_hit;

    assign wr_hit = we_i && (waddr_i != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_hit) begin
            regs_d[waddr_i] = wdata_i;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rs1_data_o = (wr_hit && (waddr_i == rs1_addr_i)) ? wdata_i : regs_q[rs1_addr_i];
        rs2_data_o = (wr_hit && (waddr_i == rs2_addr_i)) ? wdata_i : regs_q[rs2_addr_i];
    end

endmodule

// File: rtl/core_id_stage.sv
// core_id_stage
//   Decode stage of the 5-stage RV32IM core. Decodes the fetched word, reads
//   the register file, detects load-use hazards against the instruction in
//   execute, and registers a control/operand bundle for execute.
//   A bubble is the decoded NOP_INSN with valid=0 and zero PC/operands; it is
//   also the reset value of the bundle.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   d_instruction_i/pc/pc4      fetched instruction and its PCs
//   flush_i                     squash decode instruction (wins over hazard)
//   stall_i                     hold all e_* registers
//   wb_we_i/rd/data             write-back into the register file
//   hazard_stall_o              combinational load-use stall request to fetch
//   e_*                         registered bundle for execute
module core_id_stage #(
    parameter int          DATA_WIDTH     = core_id_stage_pkg::XLEN,
    parameter int          REG_ADDR_WIDTH = core_id_stage_pkg::REG_AW,
    parameter logic [31:0] NOP_INSN       = core_id_stage_pkg::NOP_INSN
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               d_instruction_i,
    input  logic [DATA_WIDTH-1:0]     d_pc_i,
    input  logic [DATA_WIDTH-1:0]     d_pc4_i,
    input  logic                      flush_i,
    input  logic                      stall_i,
    input  logic                      wb_we_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
    input  logic [DATA_WIDTH-1:0]     wb_data_i,
    output logic                      hazard_stall_o,
    output logic                      e_valid_o,
    output logic [DATA_WIDTH-1:0]     e_pc_o,
    output logic [DATA_WIDTH-1:0]     e_pc4_o,
    output logic [REG_ADDR_WIDTH-1:0] e_rs1_o,
    output logic [REG_ADDR_WIDTH-1:0] e_rs2_o,
    output logic [REG_ADDR_WIDTH-1:0] e_rd_o,
    output logic [DATA_WIDTH-1:0]     e_rs1_data_o,
    output logic [DATA_WIDTH-1:0]     e_rs2_data_o,
    output logic [DATA_WIDTH-1:0]     e_imm_o,
    output logic [4:0]                e_alu_op_o,
    output logic [1:0]                e_src_a_sel_o,
    output logic                      e_src_b_imm_o,
    output logic                      e_mem_rd_o,
    output logic                      e_mem_wr_o,
    output logic [2:0]                e_mem_size_o,
    output logic                      e_wb_en_o,
    output logic [1:0]                e_wb_sel_o,
    output logic                      e_branch_o,
    output logic                      e_jump_o,
    output logic                      e_jalr_o,
    output logic                      e_illegal_o
);

    import core_id_stage_pkg::*;

    localparam id_ctrl_t   BUBBLE_CTRL = decode_insn(NOP_INSN);
    localparam id_bundle_t BUBBLE      = '{valid: 1'b0, pc: '0, pc4: '0,
                                           rs1_data: '0, rs2_data: '0,
                                           ctrl: BUBBLE_CTRL};

    id_ctrl_t        ctrl_dec;
    id_bundle_t      bundle_d, bundle_q;
    logic [XLEN-1:0] rs1_rdata, rs2_rdata;
    logic            rs1_hit, rs2_hit, hazard;

    core_regfile #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs1_addr_i (d_instruction_i[19:15]),
        .rs2_addr_i (d_instruction_i[24:20]),
        .rs1_data_o (rs1_rdata),
        .rs2_data_o (rs2_rdata),
        .we_i       (wb_we_i),
        .waddr_i    (wb_rd_i),
        .wdata_i    (wb_data_i)
    );

    assign ctrl_dec = decode_insn(d_instruction_i);

    // Load-use: the load in execute has not produced its data yet, so a
    // consumer in decode must wait one cycle. Only sources the format really
    // reads count; a flush squashes the consumer, so no stall is needed.
    always_comb begin
        rs1_hit = uses_rs1(d_instruction_i[6:0]) && (ctrl_dec.rs1 == bundle_q.ctrl.rd);
        rs2_hit = uses_rs2(d_instruction_i[6:0]) && (ctrl_dec.rs2 == bundle_q.ctrl.rd);
        hazard  = bundle_q.valid && bundle_q.ctrl.mem_rd && (bundle_q.ctrl.rd != '0) &&
                  (rs1_hit || rs2_hit) && !flush_i;
    end

    assign hazard_stall_o = hazard;

    always_comb begin
        bundle_d = bundle_q;
        if (!stall_i) begin
            if (flush_i || hazard) begin
                bundle_d = BUBBLE;
            end else begin
                bundle_d.valid    = 1'b1;
                bundle_d.pc       = d_pc_i;
                bundle_d.pc4      = d_pc4_i;
                bundle_d.rs1_data = rs1_rdata;
                bundle_d.rs2_data = rs2_rdata;
                bundle_d.ctrl     = ctrl_dec;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bundle_q <= BUBBLE;
        end else begin
            bundle_q <= bundle_d;
        end
    end

    assign e_valid_o     = bundle_q.valid;
    assign e_pc_o        = bundle_q.pc;
    assign e_pc4_o       = bundle_q.pc4;
    assign e_rs1_o       = bundle_q.ctrl.rs1;
    assign e_rs2_o       = bundle_q.ctrl.rs2;
    assign e_rd_o        = bundle_q.ctrl.rd;
    assign e_rs1_data_o  = bundle_q.rs1_data;
    assign e_rs2_data_o  = bundle_q.rs2_data;
    assign e_imm_o       = bundle_q.ctrl.imm;
    assign e_alu_op_o    = bundle_q.ctrl.alu_op;
    assign e_src_a_sel_o = bundle_q.ctrl.src_a_sel;
    assign e_src_b_imm_o = bundle_q.ctrl.src_b_imm;
    assign e_mem_rd_o    = bundle_q.ctrl.mem_rd;
    assign e_mem_wr_o    = bundle_q.ctrl.mem_wr;
    assign e_mem_size_o  = bundle_q.ctrl.mem_size;
    assign e_wb_en_o     = bundle_q.ctrl.wb_en;
    assign e_wb_sel_o    = bundle_q.ctrl.wb_sel;
    assign e_branch_o    = bundle_q.ctrl.branch;
    assign e_jump_o      = bundle_q.ctrl.jump;
    assign e_jalr_o      = bundle_q.ctrl.jalr;
    assign e_illegal_o   = bundle_q.ctrl.illegal;

endmodule

// File: tb/tb_core_id_stage.sv
// Bench for core_id_stage: directed scenarios with a scoreboard queue of
// expected bundles and a reference register-file model for operand values.
module tb_core_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] d_instruction_i, d_pc_i, d_pc4_i;
    logic        flush_i, stall_i, wb_we_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        hazard_stall_o, e_valid_o;
    logic [31:0] e_pc_o, e_pc4_o, e_rs1_data_o, e_rs2_data_o, e_imm_o;
    logic [4:0]  e_rs1_o, e_rs2_o, e_rd_o, e_alu_op_o;
    logic [1:0]  e_src_a_sel_o, e_wb_sel_o;
    logic        e_src_b_imm_o, e_mem_rd_o, e_mem_wr_o, e_wb_en_o;
    logic [2:0]  e_mem_size_o;
    logic        e_branch_o, e_jump_o, e_jalr_o, e_illegal_o;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        wb_en;
        logic [1:0]  src_a;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] regs_m [32];

    // decode table: insn, rd, imm, wb_en, src_a
    logic [31:0] dt_insn [5] = '{32'h0000_0013, 32'h0050_0093, 32'hFFF0_0293,
                                 32'h1234_52B7, 32'h0080_00EF};
    logic [4:0]  dt_rd   [5] = '{5'd0, 5'd1, 5'd5, 5'd5, 5'd1};
    logic [31:0] dt_imm  [5] = '{32'h0, 32'h5, 32'hFFFF_FFFF, 32'h1234_5000, 32'h8};
    logic        dt_wb   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0]  dt_srca [5] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd1};

    always #5 clk = ~clk;

    core_id_stage dut (
        .clk(clk), .rst_n(rst_n),
        .d_instruction_i(d_instruction_i), .d_pc_i(d_pc_i), .d_pc4_i(d_pc4_i),
        .flush_i(flush_i), .stall_i(stall_i),
        .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .hazard_stall_o(hazard_stall_o), .e_valid_o(e_valid_o),
        .e_pc_o(e_pc_o), .e_pc4_o(e_pc4_o),
        .e_rs1_o(e_rs1_o), .e_rs2_o(e_rs2_o), .e_rd_o(e_rd_o),
        .e_rs1_data_o(e_rs1_data_o), .e_rs2_data_o(e_rs2_data_o),
        .e_imm_o(e_imm_o), .e_alu_op_o(e_alu_op_o),
        .e_src_a_sel_o(e_src_a_sel_o), .e_src_b_imm_o(e_src_b_imm_o),
        .e_mem_rd_o(e_mem_rd_o), .e_mem_wr_o(e_mem_wr_o), .e_mem_size_o(e_mem_size_o),
        .e_wb_en_o(e_wb_en_o), .e_wb_sel_o(e_wb_sel_o),
        .e_branch_o(e_branch_o), .e_jump_o(e_jump_o), .e_jalr_o(e_jalr_o),
        .e_illegal_o(e_illegal_o)
    );

    // Inputs change on the falling edge; the model commits write-back on the
    // rising edge; outputs are examined on the following falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n && wb_we_i && wb_rd_i != 5'd0) regs_m[wb_rd_i] = wb_data_i;
        @(negedge clk);
    endtask

    task automatic set_insn(input logic [31:0] insn, input logic [31:0] pc);
        d_instruction_i = insn;
        d_pc_i          = pc;
        d_pc4_i         = pc + 32'd4;
    endtask

    // Expected register read including the write-first bypass.
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (wb_we_i && wb_rd_i == a) return wb_data_i;
        return regs_m[a];
    endfunction

    function automatic exp_t mk(input logic v, input logic [4:0] rd, input logic [31:0] imm,
                                input logic wb, input logic [1:0] sa, input logic [31:0] pc,
                                input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        e.valid = v; e.rd = rd; e.imm = imm; e.wb_en = wb; e.src_a = sa; e.pc = pc;
        e.rs1_data = exp_rd(r1); e.rs2_data = exp_rd(r2);
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        set_insn(32'h0000_0013, 32'h0);
        flush_i = 0; stall_i = 0; wb_we_i = 0; wb_rd_i = 0; wb_data_i = 0;
        for (int i = 0; i < 32; i++) regs_m[i] = 32'h0;
        repeat (2) @(negedge clk);
        n_cmp++; if (e_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", e_valid_o); end
        n_cmp++; if (e_src_b_imm_o !== 1'b1) begin n_err++; $display("FAIL reset_src_b_imm: got %b want 1", e_src_b_imm_o); end
        n_cmp++; if (e_alu_op_o !== 5'd0) begin n_err++; $display("FAIL reset_alu_op: got %h want 0", e_alu_op_o); end
        n_cmp++; if (e_wb_en_o !== 1'b0) begin n_err++; $display("FAIL reset_wb_en: got %b want 0", e_wb_en_o); end
        n_cmp++; if (e_pc_o !== 32'h0 || e_imm_o !== 32'h0 || e_rd_o !== 5'd0) begin
            n_err++; $display("FAIL reset_fields: pc %h imm %h rd %0d want all 0", e_pc_o, e_imm_o, e_rd_o); end
        n_cmp++; if (hazard_stall_o !== 1'b0) begin n_err++; $display("FAIL reset_hazard: got %b want 0", hazard_stall_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_decode();
        exp_t ex;
        for (int i = 0; i < 5; i++) begin
            set_insn(dt_insn[i], 32'h100 + 32'(4 * i));
            sb.push_back(mk(1'b1, dt_rd[i], dt_imm[i], dt_wb[i], dt_srca[i], 32'h100 + 32'(4 * i), 5'd0, 5'd0));
            tick();
            ex = sb.pop_front();
            n_cmp++; if (e_valid_o !== ex.valid) begin n_err++; $display("FAIL dec%0d_valid: got %b want %b", i, e_valid_o, ex.valid); end
            n_cmp++; if (e_rd_o !== ex.rd) begin n_err++; $display("FAIL dec%0d_rd: got %0d want %0d", i, e_rd_o, ex.rd); end
            n_cmp++; if (e_imm_o !== ex.imm) begin n_err++; $display("FAIL dec%0d_imm: got %h want %h", i, e_imm_o, ex.imm); end
            n_cmp++; if (e_wb_en_o !== ex.wb_en) begin n_err++; $display("FAIL dec%0d_wb_en: got %b want %b", i, e_wb_en_o, ex.wb_en); end
            n_cmp++; if (e_src_a_sel_o !== ex.src_a) begin n_err++; $display("FAIL dec%0d_src_a: got %0d want %0d", i, e_src_a_sel_o, ex.src_a); end
            n_cmp++; if (e_src_b_imm_o !== 1'b1 || e_alu_op_o !== 5'd0) begin
                n_err++; $display("FAIL dec%0d_alu: src_b_imm %b alu_op %h want 1/00", i, e_src_b_imm_o, e_alu_op_o); end
            n_cmp++; if (e_pc_o !== ex.pc || e_pc4_o !== ex.pc + 32'd4) begin
                n_err++; $display("FAIL dec%0d_pc: got %h/%h want %h", i, e_pc_o, e_pc4_o, ex.pc); end
        end
    endtask

    task automatic test_bypass();
        exp_t ex;
        set_insn(32'h0000_0013, 32'h180);
        wb_we_i = 1; wb_rd_i = 5'd2; wb_data_i = 32'h0000_55AA;
        tick();
        for (int i = 0; i < 2; i++) begin
            set_insn(32'h0011_01B3, 32'h184);          // add x3,x2,x1
            wb_we_i = (i == 0); wb_rd_i = 5'd1; wb_data_i = 32'h0000_1234;
            sb.push_back(mk(1'b1, 5'd3, 32'h0, 1'b1, 2'd0, 32'h184, 5'd2, 5'd1));
            tick();
            ex = sb.pop_front();
            n_cmp++; if (e_rs2_data_o !== ex.rs2_data) begin n_err++; $display("FAIL bypass%0d_rs2: got %h want %h", i, e_rs2_data_o, ex.rs2_data); end
            n_cmp++; if (e_rs1_data_o !== ex.rs1_data) begin n_err++; $display("FAIL bypass%0d_rs1: got %h want %h", i, e_rs1_data_o, ex.rs1_data); end
            n_cmp++; if (e_src_b_imm_o !== 1'b0 || e_rd_o !== ex.rd) begin
                n_err++; $display("FAIL bypass%0d_ctl: src_b_imm %b rd %0d want 0/%0d", i, e_src_b_imm_o, e_rd_o, ex.rd); end
        end
        wb_we_i = 0;
    endtask

    task automatic test_load_use();
        exp_t ex;
        set_insn(32'h0000_A103, 32'h200);              // lw x2,0(x1)
        tick();
        n_cmp++; if (e_mem_rd_o !== 1'b1 || e_rd_o !== 5'd2 || e_wb_en_o !== 1'b1 || e_wb_sel_o !== 2'd1) begin
            n_err++; $display("FAIL lw_decode: mem_rd %b rd %0d wb_en %b wb_sel %0d want 1/2/1/1", e_mem_rd_o, e_rd_o, e_wb_en_o, e_wb_sel_o); end
        set_insn(32'h0011_01B3, 32'h204);              // add x3,x2,x1 (rs1 hit)
        #1;
        n_cmp++; if (hazard_stall_o !== 1'b1) begin n_err++; $display("FAIL lu_hazard_rs1: got %b want 1", hazard_stall_o); end
        tick();
        n_cmp++; if (e_valid_o !== 1'b0 || e_wb_en_o !== 1'b0) begin n_err++; $display("FAIL lu_bubble: valid %b wb_en %b want 0/0", e_valid_o, e_wb_en_o); end
        #1;
        n_cmp++; if (hazard_stall_o !== 1'b0) begin n_err++; $display("FAIL lu_hazard_clear: got %b want 0", hazard_stall_o); end
        sb.push_back(mk(1'b1, 5'd3, 32'h0, 1'b1, 2'd0, 32'h204, 5'd2, 5'd1));
        tick();
        ex = sb.pop_front();
        n_cmp++; if (e_valid_o !== ex.valid || e_rd_o !== ex.rd || e_pc_o !== ex.pc) begin
            n_err++; $display("FAIL lu_issue: valid %b rd %0d pc %h want 1/%0d/%h", e_valid_o, e_rd_o, e_pc_o, ex.rd, ex.pc); end
        // rs2 hit on an R-type consumer
        set_insn(32'h0000_A083, 32'h210);              // lw x1,0(x1)
        tick();
        set_insn(32'h0011_01B3, 32'h214);
        #1;
        n_cmp++; if (hazard_stall_o !== 1'b1) begin n_err++; $display("FAIL lu_hazard_rs2: got %b want 1", hazard_stall_o); end
        tick(); tick();
        // rs2 field matches but I-type does not read rs2
        set_insn(32'h0000_A203, 32'h220);              // lw x4,0(x1)
        tick();
        set_insn(32'h0040_0093, 32'h224);              // addi x1,x0,4
        #1;
        n_cmp++; if (hazard_stall_o !== 1'b0) begin n_err++; $display("FAIL lu_unused_rs2: got %b want 0", hazard_stall_o); end
        tick();
        // load into x0 never stalls
        set_insn(32'h0000_A003, 32'h230);              // lw x0,0(x1)
        tick();
        set_insn(32'h0000_01B3, 32'h234);              // add x3,x0,x0
        #1;
        n_cmp++; if (hazard_stall_o !== 1'b0) begin n_err++; $display("FAIL lu_x0: got %b want 0", hazard_stall_o); end
        tick();
    endtask

    task automatic test_flush();
        set_insn(32'h0011_01B3, 32'h300);
        flush_i = 1;
        tick();
        n_cmp++; if (e_valid_o !== 1'b0 || e_wb_en_o !== 1'b0) begin n_err++; $display("FAIL flush_bubble: valid %b wb_en %b want 0/0", e_valid_o, e_wb_en_o); end
        flush_i = 0;
        set_insn(32'h0000_A103, 32'h304);
        tick();
        set_insn(32'h0011_01B3, 32'h308);
        flush_i = 1;
        #1;
        n_cmp++; if (hazard_stall_o !== 1'b0) begin n_err++; $display("FAIL flush_hides_hazard: got %b want 0", hazard_stall_o); end
        tick();
        n_cmp++; if (e_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_over_hazard: valid %b want 0", e_valid_o); end
        flush_i = 0;
    endtask

    task automatic test_stall();
        exp_t ex;
        set_insn(32'h0050_0093, 32'h400);
        tick();
        stall_i = 1;
        set_insn(32'hFFF0_0293, 32'h404);
        wb_we_i = 1; wb_rd_i = 5'd6; wb_data_i = 32'h0000_0077;
        for (int i = 0; i < 3; i++) begin
            tick();
            wb_we_i = 0;
            n_cmp++; if (e_valid_o !== 1'b1 || e_rd_o !== 5'd1 || e_imm_o !== 32'h5 || e_pc_o !== 32'h400) begin
                n_err++; $display("FAIL stall_hold%0d: valid %b rd %0d imm %h pc %h want 1/1/5/400", i, e_valid_o, e_rd_o, e_imm_o, e_pc_o); end
        end
        stall_i = 0;
        set_insn(32'h0003_03B3, 32'h408);              // add x7,x6,x0
        sb.push_back(mk(1'b1, 5'd7, 32'h0, 1'b1, 2'd0, 32'h408, 5'd6, 5'd0));
        tick();
        ex = sb.pop_front();
        n_cmp++; if (e_rs1_data_o !== ex.rs1_data || e_rd_o !== ex.rd || e_illegal_o !== 1'b0) begin
            n_err++; $display("FAIL stall_wb: rs1_data %h rd %0d illegal %b want %h/%0d/0", e_rs1_data_o, e_rd_o, e_illegal_o, ex.rs1_data, ex.rd); end
    endtask

    task automatic test_illegal();
        set_insn(32'hFFFF_FFFF, 32'h500);
        tick();
        n_cmp++; if (e_illegal_o !== 1'b1 || e_valid_o !== 1'b1) begin n_err++; $display("FAIL illegal_flag: illegal %b valid %b want 1/1", e_illegal_o, e_valid_o); end
        n_cmp++; if (e_wb_en_o !== 1'b0 || e_mem_rd_o !== 1'b0 || e_mem_wr_o !== 1'b0) begin
            n_err++; $display("FAIL illegal_effects: wb_en %b mem_rd %b mem_wr %b want 0/0/0", e_wb_en_o, e_mem_rd_o, e_mem_wr_o); end
    endtask

    task automatic test_x0();
        exp_t ex;
        for (int i = 0; i < 2; i++) begin
            set_insn(32'h0000_01B3, 32'h600);          // add x3,x0,x0
            wb_we_i = (i == 0); wb_rd_i = 5'd0; wb_data_i = 32'h0000_DEAD;
            sb.push_back(mk(1'b1, 5'd3, 32'h0, 1'b1, 2'd0, 32'h600, 5'd0, 5'd0));
            tick();
            ex = sb.pop_front();
            n_cmp++; if (e_rs1_data_o !== ex.rs1_data || e_rs2_data_o !== ex.rs2_data) begin
                n_err++; $display("FAIL x0_read%0d: rs1 %h rs2 %h want %h/%h", i, e_rs1_data_o, e_rs2_data_o, ex.rs1_data, ex.rs2_data); end
        end
        wb_we_i = 0;
    endtask

    task automatic test_async_reset();
        exp_t ex;
        set_insn(32'h0011_01B3, 32'h700);
        @(posedge clk);
        #2 rst_n = 1'b0;
        for (int i = 0; i < 32; i++) regs_m[i] = 32'h0;
        #1;
        n_cmp++; if (e_valid_o !== 1'b0 || e_rd_o !== 5'd0 || e_rs1_data_o !== 32'h0) begin
            n_err++; $display("FAIL async_reset: valid %b rd %0d rs1_data %h want 0/0/0", e_valid_o, e_rd_o, e_rs1_data_o); end
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(mk(1'b1, 5'd3, 32'h0, 1'b1, 2'd0, 32'h700, 5'd2, 5'd1));
        tick();
        ex = sb.pop_front();
        n_cmp++; if (e_rs1_data_o !== ex.rs1_data || e_rs2_data_o !== ex.rs2_data || e_valid_o !== 1'b1) begin
            n_err++; $display("FAIL reset_regfile: rs1 %h rs2 %h valid %b want %h/%h/1", e_rs1_data_o, e_rs2_data_o, e_valid_o, ex.rs1_data, ex.rs2_data); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_bypass();
        test_load_use();
        test_flush();
        test_stall();
        test_illegal();
        test_x0();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
